// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the program loader.
// The loader takes the master side; the byte source and memory take the slave side.
interface prog_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        pm_we;
  logic [7:0]  pm_addr;
  logic [23:0] pm_wdata;

  modport master (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output pm_we,
    output pm_addr,
    output pm_wdata
  );

  modport slave (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  pm_we,
    input  pm_addr,
    input  pm_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream program loader: assembles 24-bit words into program memory and holds the
// CPU in reset until a frame's checksum is verified.
module prog_loader #(
  parameter logic [7:0]  HDR_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  prog_loader_if.master bus,
  input  logic          start,
  output logic          cpu_rst_n,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code
);

  localparam int unsigned     TmoW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    StHdr, StCnt, StB2, StB1, StB0, StWr, StChk, StDone, StErr
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic            we_q, we_d;
  logic [7:0]      addr_q, addr_d;
  logic [23:0]     wdata_q, wdata_d;
  logic            cpu_rst_n_q, cpu_rst_n_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [8:0]      cnt_q, cnt_d;
  logic [7:0]      sum_q, sum_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            accept;
  logic            timed;

  assign accept = bus.byte_valid && ready_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    err_code_d = err_code_q;
    tmo_d      = '0;
    timed      = 1'b0;

    unique case (state_q)
      StHdr: begin
        if (accept && bus.byte_data == HDR_BYTE) state_d = StCnt;
      end
      StCnt: begin
        timed = 1'b1;
        if (accept) begin
          cnt_d   = (bus.byte_data == 8'd0) ? 9'd256 : {1'b0, bus.byte_data};
          sum_d   = bus.byte_data;
          addr_d  = '0;
          state_d = StB2;
        end
      end
      StB2: begin
        timed = 1'b1;
        if (accept) begin
          wdata_d[23:16] = bus.byte_data;
          sum_d          = sum_q + bus.byte_data;
          state_d        = StB1;
        end
      end
      StB1: begin
        timed = 1'b1;
        if (accept) begin
          wdata_d[15:8] = bus.byte_data;
          sum_d         = sum_q + bus.byte_data;
          state_d       = StB0;
        end
      end
      StB0: begin
        timed = 1'b1;
        if (accept) begin
          wdata_d[7:0] = bus.byte_data;
          sum_d        = sum_q + bus.byte_data;
          state_d      = StWr;
        end
      end
      StWr: begin
        timed   = 1'b1;
        addr_d  = addr_q + 8'd1;
        cnt_d   = cnt_q - 9'd1;
        state_d = (cnt_q == 9'd1) ? StChk : StB2;
      end
      StChk: begin
        timed = 1'b1;
        if (accept) begin
          if (bus.byte_data == sum_q) begin
            state_d = StDone;
          end else begin
            state_d    = StErr;
            err_code_d = 2'd1;
          end
        end
      end
      StDone, StErr: begin
        if (start) begin
          state_d    = StHdr;
          err_code_d = 2'd0;
        end
      end
      default: state_d = StHdr;
    endcase

    // Inter-byte watchdog; an abort overrides whatever the state above chose.
    if (timed) begin
      if (accept) begin
        tmo_d = '0;
      end else if (tmo_q == TmoLast) begin
        state_d    = StErr;
        err_code_d = 2'd2;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_comb begin
    ready_d     = state_d inside {StHdr, StCnt, StB2, StB1, StB0, StChk};
    we_d        = (state_d == StWr);
    busy_d      = state_d inside {StCnt, StB2, StB1, StB0, StWr, StChk};
    done_d      = (state_d == StDone);
    err_d       = (state_d == StErr);
    cpu_rst_n_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StHdr;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.byte_ready = ready_q;
  assign bus.pm_we      = we_q;
  assign bus.pm_addr    = addr_q;
  assign bus.pm_wdata   = wdata_q;
  assign cpu_rst_n      = cpu_rst_n_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign err_code       = err_code_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized bench for prog_loader: frames are checked against a frame-level reference model
// that predicts the word writes and the final load status.
module tb_prog_loader;
  localparam int unsigned Tmo = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cpu_rst_n;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  prog_loader_if ifc ();

  prog_loader #(
    .HDR_BYTE   (8'hA5),
    .TIMEOUT_CYC(Tmo)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (ifc),
    .start    (start),
    .cpu_rst_n(cpu_rst_n),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int last_acc = 0;

  logic [7:0]  stim[$];
  logic [31:0] exp_wr[$];
  logic [31:0] wr_q[$];
  int          exp_code;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (rst_n && ifc.pm_we) wr_q.push_back({ifc.pm_addr, ifc.pm_wdata});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Frame-level model: hunt the header, unpack N words MSB first, compare the mod-256 sum.
  task automatic predict();
    int         i = 0;
    int         nw;
    logic [7:0] sum;
    exp_wr.delete();
    while (stim[i] != 8'hA5) i++;
    i++;
    nw  = (stim[i] == 8'd0) ? 256 : int'(stim[i]);
    sum = stim[i];
    i++;
    for (int w = 0; w < nw; w++) begin
      exp_wr.push_back({8'(w), stim[i], stim[i+1], stim[i+2]});
      sum = sum + stim[i] + stim[i+1] + stim[i+2];
      i += 3;
    end
    exp_code = (stim[i] == sum) ? 0 : 1;
  endtask

  task automatic build_frame(input int nw);
    logic [7:0] s;
    logic [7:0] b;
    stim.push_back(8'hA5);
    b = 8'(nw);
    stim.push_back(b);
    s = b;
    repeat (3 * nw) begin
      b = 8'($urandom);
      stim.push_back(b);
      s = s + b;
    end
    stim.push_back(s);
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap, input bit poke);
    int unsigned w = 0;
    ifc.byte_valid = 1'b0;
    repeat (gap) begin
      start = poke && ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    ifc.byte_valid = 1'b1;
    ifc.byte_data  = b;
    while (!ifc.byte_ready && w < 40) begin
      start = poke && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      w++;
    end
    if (!ifc.byte_ready) begin
      check("byte_accept", ifc.byte_ready, 1'b1);
      ifc.byte_valid = 1'b0;
      start = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    ifc.byte_valid = 1'b0;
    start = 1'b0;
    last_acc = cyc;
  endtask

  task automatic run_frame(input int unsigned max_gap, input bit poke);
    int n;
    wr_q.delete();
    predict();
    for (int k = 0; k < stim.size(); k++) begin
      if (k == stim.size() - 1) check("cpu_rst_pre", cpu_rst_n, 1'b0);
      send_byte(stim[k], $urandom_range(0, max_gap), poke);
    end
    check("done", done, exp_code == 0);
    check("err", err, exp_code == 1);
    check("err_code", err_code, exp_code);
    check("cpu_rst_n", cpu_rst_n, exp_code == 0);
    check("busy_end", busy, 1'b0);
    check("ready_end", ifc.byte_ready, 1'b0);
    check("pm_addr_end", ifc.pm_addr, 8'(exp_wr.size()));
    check("n_writes", wr_q.size(), exp_wr.size());
    n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
    for (int k = 0; k < n; k++) check($sformatf("write[%0d]", k), wr_q[k], exp_wr[k]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_done", done, 1'b0);
    check("start_err", err, 1'b0);
    check("start_code", err_code, 2'd0);
    check("start_cpu_rst", cpu_rst_n, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, ifc.byte_ready, 1'b0);
    check({tag, "_we"}, ifc.pm_we, 1'b0);
    check({tag, "_addr"}, ifc.pm_addr, 8'd0);
    check({tag, "_wdata"}, ifc.pm_wdata, 24'd0);
    check({tag, "_cpu_rst"}, cpu_rst_n, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_err"}, err, 1'b0);
    check({tag, "_code"}, err_code, 2'd0);
  endtask

  initial begin
    int w;
    rst_n          = 1'b0;
    start          = 1'b0;
    ifc.byte_valid = 1'b0;
    ifc.byte_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_values("rst");
    rst_n = 1'b1;

    // 02+10+20+01+1C+00+05 = 54 (mod 256)
    stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h01, 8'h1C, 8'h00, 8'h05, 8'h54};
    run_frame(0, 1'b0);

    pulse_start();
    stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h01, 8'h1C, 8'h00, 8'h05, 8'h5D};
    run_frame(3, 1'b0);
    pulse_start();
    stim = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h01, 8'h1C, 8'h00, 8'h05, 8'h54};
    run_frame(5, 1'b1);

    pulse_start();
    stim = '{8'h00, 8'hFF, 8'h13};
    build_frame(3);
    run_frame(4, 1'b0);

    // Stall mid-word: abort lands exactly Tmo cycles after the last accepted byte.
    pulse_start();
    wr_q.delete();
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h01, 0, 1'b0);
    send_byte(8'h10, 0, 1'b0);
    w = 0;
    while (!err && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("tmo_err", err, 1'b1);
    check("tmo_delay", cyc - last_acc, Tmo);
    check("tmo_code", err_code, 2'd2);
    check("tmo_cpu_rst", cpu_rst_n, 1'b0);
    repeat (5) @(negedge clk);
    check("tmo_no_write", wr_q.size(), 0);

    pulse_start();
    stim.delete();
    build_frame(256);
    run_frame(2, 1'b0);

    for (int f = 0; f < 4; f++) begin
      pulse_start();
      stim.delete();
      build_frame($urandom_range(1, 20));
      if ($urandom_range(0, 2) == 0) stim[stim.size()-1] = stim[stim.size()-1] ^ 8'h01;
      run_frame(8, 1'b1);
    end

    // Asynchronous reset in the middle of a payload.
    pulse_start();
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h05, 0, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(8'(k + 8'h31), 1, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    stim.delete();
    build_frame(6);
    run_frame(6, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
